// File: rtl/rv32i_pkg.sv
// Shared constants and FSM encoding for the rv32i memory subsystem.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam logic [3:0] BE_WORD = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ_I  = 3'd1,
        ST_REQ_D  = 3'd2,
        ST_WAIT_I = 3'd3,
        ST_WAIT_D = 3'd4
    } state_t;

endpackage

// File: rtl/rv32i_arb_prio.sv
// Fetch/data priority decision with a streak limiter so that a continuously
// requesting fetch port cannot be starved by back-to-back data accesses.
module rv32i_arb_prio
    import rv32i_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_if_valid,
    input  logic i_d_valid,
    input  logic i_idle,
    output logic o_if_gnt,
    output logic o_d_gnt
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    logic [3:0] r_streak;
    logic       w_d_wins;

    always_comb begin
        w_d_wins = i_d_valid && (!i_if_valid || (r_streak < STREAK_MAX));
        o_d_gnt  = i_idle && w_d_wins;
        o_if_gnt = i_idle && i_if_valid && !w_d_wins;
    end

    // Only contended data wins count toward the streak; any fetch win resets it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_streak <= '0;
        end else if (o_if_gnt) begin
            r_streak <= '0;
        end else if (o_d_gnt && i_if_valid && (r_streak < STREAK_MAX)) begin
            r_streak <= r_streak + 4'd1;
        end
    end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Shares one single-port memory between the instruction-fetch and load/store
// ports, serialising one request/grant/response transaction at a time.
module rv32i_mem_arbiter
    import rv32i_pkg::*;
#(
    parameter int XLEN         = rv32i_pkg::XLEN,
    parameter int MAX_D_STREAK = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_rsp_valid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            d_req_valid,
    output logic            d_req_ready,
    input  logic            d_we,
    input  logic [3:0]      d_be,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_rsp_valid,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    state_t          r_state;
    state_t          w_next_state;
    logic            w_idle;
    logic            w_if_gnt;
    logic            w_d_gnt;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [3:0]      r_mem_be;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;
    logic            r_if_rsp_valid;
    logic            r_d_rsp_valid;
    logic [XLEN-1:0] r_if_rdata;
    logic [XLEN-1:0] r_d_rdata;

    assign w_idle = (r_state == ST_IDLE);

    rv32i_arb_prio #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_prio (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .i_if_valid (if_req_valid),
        .i_d_valid  (d_req_valid),
        .i_idle     (w_idle),
        .o_if_gnt   (w_if_gnt),
        .o_d_gnt    (w_d_gnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_d_gnt) begin
                    w_next_state = ST_REQ_D;
                end else if (w_if_gnt) begin
                    w_next_state = ST_REQ_I;
                end
            end
            ST_REQ_I:  if (r_mem_req && mem_gnt) w_next_state = ST_WAIT_I;
            ST_REQ_D:  if (r_mem_req && mem_gnt) w_next_state = ST_WAIT_D;
            ST_WAIT_I: if (mem_rvalid) w_next_state = ST_IDLE;
            ST_WAIT_D: if (mem_rvalid) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Request fields are captured at accept and frozen until the next accept,
    // so the memory sees a stable request while it withholds the grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_d_gnt) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= d_we;
            r_mem_be    <= d_be;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
        end else if (w_if_gnt) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_be    <= BE_WORD;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
        end else if (r_mem_req && mem_gnt) begin
            r_mem_req   <= 1'b0;
        end
    end

    // Completions outside the WAIT states (e.g. stale after a reset) are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_if_rsp_valid <= 1'b0;
            r_d_rsp_valid  <= 1'b0;
            r_if_rdata     <= '0;
            r_d_rdata      <= '0;
        end else begin
            r_if_rsp_valid <= (r_state == ST_WAIT_I) && mem_rvalid;
            r_d_rsp_valid  <= (r_state == ST_WAIT_D) && mem_rvalid;
            if ((r_state == ST_WAIT_I) && mem_rvalid) begin
                r_if_rdata <= mem_rdata;
            end
            if ((r_state == ST_WAIT_D) && mem_rvalid) begin
                r_d_rdata <= r_mem_we ? '0 : mem_rdata;
            end
        end
    end

    assign if_req_ready = w_if_gnt;
    assign d_req_ready  = w_d_gnt;
    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_be       = r_mem_be;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign if_rsp_valid = r_if_rsp_valid;
    assign if_rdata     = r_if_rdata;
    assign d_rsp_valid  = r_d_rsp_valid;
    assign d_rdata      = r_d_rdata;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter with a small programmable memory responder.
module tb_rv32i_mem_arbiter;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req_valid, d_req_ready, d_we, d_rsp_valid;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int          total = 0;
    int          bad = 0;
    bit          memAuto = 1'b1;
    int          gntDelay = 0;
    int          waitCnt;
    logic [31:0] gntAddr;
    logic        manGnt = 1'b0;
    logic        manRvalid = 1'b0;
    logic [31:0] manRdata = 32'h0;

    rv32i_mem_arbiter #(.XLEN(32), .MAX_D_STREAK(4)) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_addr      (if_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rdata     (if_rdata),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_we         (d_we),
        .d_be         (d_be),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rsp_valid  (d_rsp_valid),
        .d_rdata      (d_rdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] readWord(input logic [31:0] a);
        if (a == 32'h4) return 32'h00500893;
        return a ^ 32'h12345678;
    endfunction

    // Memory responder: grant after gntDelay waiting cycles, complete one cycle later.
    initial begin
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 32'h0;
        waitCnt = 0;
        gntAddr = 32'h0;
        forever begin
            @(negedge clk);
            if (memAuto) begin
                mem_rvalid = mem_gnt;
                if (mem_gnt) mem_rdata = readWord(gntAddr);
                if (mem_req) begin
                    if (waitCnt >= gntDelay) begin
                        mem_gnt = 1'b1;
                        gntAddr = mem_addr;
                        waitCnt = 0;
                    end else begin
                        mem_gnt = 1'b0;
                        waitCnt++;
                    end
                end else begin
                    mem_gnt = 1'b0;
                    waitCnt = 0;
                end
            end else begin
                mem_gnt = manGnt;
                mem_rvalid = manRvalid;
                mem_rdata = manRdata;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [3:0] be, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rdata, output logic ok);
        int n;
        @(negedge clk);
        d_req_valid = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
        #4;
        n = 0;
        while (!d_req_ready && n < 50) begin @(negedge clk); #4; n++; end
        ok = d_req_ready;
        @(negedge clk);
        d_req_valid = 1'b0;
        #4;
        n = 0;
        while (!d_rsp_valid && n < 50) begin @(negedge clk); #4; n++; end
        ok = ok && d_rsp_valid;
        rdata = d_rdata;
    endtask

    task automatic doFetch(input logic [31:0] addr, output logic [31:0] rdata, output logic ok);
        int n;
        @(negedge clk);
        if_req_valid = 1'b1; if_addr = addr;
        #4;
        n = 0;
        while (!if_req_ready && n < 50) begin @(negedge clk); #4; n++; end
        ok = if_req_ready;
        @(negedge clk);
        if_req_valid = 1'b0;
        #4;
        n = 0;
        while (!if_rsp_valid && n < 50) begin @(negedge clk); #4; n++; end
        ok = ok && if_rsp_valid;
        rdata = if_rdata;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        ok;
        logic [9:0]  expSeq;
        int          nGr;
        int          n;

        reset_n = 1'b0;
        if_req_valid = 1'b0; if_addr = 32'h0;
        d_req_valid = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;

        // Reset state
        @(negedge clk); #4;
        checkOutput("rstMemReq", 32'(mem_req), 32'h0);
        checkOutput("rstMemBe", 32'(mem_be), 32'h0);
        checkOutput("rstRsp", 32'({if_rsp_valid, d_rsp_valid}), 32'h0);
        checkOutput("rstState", 32'(u_dut.r_state), 32'(ST_IDLE));
        @(negedge clk);
        reset_n = 1'b1;

        // Single fetch with immediate memory
        @(negedge clk);
        if_req_valid = 1'b1; if_addr = 32'h4;
        #4;
        checkOutput("f1Ready", 32'({if_req_ready, d_req_ready}), 32'h2);
        @(negedge clk);
        if_req_valid = 1'b0;
        #4;
        checkOutput("f1MemReq", 32'(mem_req), 32'h1);
        checkOutput("f1MemAddr", mem_addr, 32'h4);
        checkOutput("f1MemWeBe", 32'({mem_we, mem_be}), 32'h0F);
        checkOutput("f1MemWdata", mem_wdata, 32'h0);
        @(negedge clk); #4;
        checkOutput("f1N2", 32'({mem_req, if_rsp_valid}), 32'h0);
        @(negedge clk); #4;
        checkOutput("f1RspValid", 32'({if_rsp_valid, d_rsp_valid}), 32'h2);
        checkOutput("f1Rdata", if_rdata, 32'h00500893);
        @(negedge clk); #4;
        checkOutput("f1Pulse", 32'(if_rsp_valid), 32'h0);
        checkOutput("f1Hold", if_rdata, 32'h00500893);

        // Data alone: ten loads, no contention
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 4'hF, 32'h200 + 32'(4 * i), 32'h0, rd, ok);
            checkOutput($sformatf("load%0dDone", i), 32'(ok), 32'h1);
            checkOutput($sformatf("load%0dData", i), rd, (32'h200 + 32'(4 * i)) ^ 32'h12345678);
        end
        checkOutput("aloneStreak", 32'(u_dut.u_prio.r_streak), 32'h0);

        // Contended: data wins first, then the fetch
        @(negedge clk);
        if_req_valid = 1'b1; if_addr = 32'h8;
        d_req_valid = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h204;
        #4;
        checkOutput("contReady", 32'({if_req_ready, d_req_ready}), 32'h1);
        @(negedge clk);
        d_req_valid = 1'b0;
        #4;
        checkOutput("contStreak", 32'(u_dut.u_prio.r_streak), 32'h1);
        n = 0;
        while (!if_req_ready && n < 20) begin @(negedge clk); #4; n++; end
        checkOutput("contFetchGnt", 32'(if_req_ready), 32'h1);
        @(negedge clk);
        if_req_valid = 1'b0;
        #4;
        n = 0;
        while (!if_rsp_valid && n < 20) begin @(negedge clk); #4; n++; end
        checkOutput("contFetchData", if_rdata, 32'h12345670);
        checkOutput("contDLoad", d_rdata, 32'h1234547C);
        checkOutput("contStreakClr", 32'(u_dut.u_prio.r_streak), 32'h0);

        // Store with a 3-cycle grant delay
        gntDelay = 3;
        @(negedge clk);
        d_req_valid = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
        #4;
        checkOutput("stReady", 32'(d_req_ready), 32'h1);
        @(negedge clk);
        d_req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #4;
            checkOutput($sformatf("stReq%0d", k), 32'({mem_req, mem_we, mem_be}), 32'h33);
            checkOutput($sformatf("stAddr%0d", k), mem_addr, 32'h100);
            checkOutput($sformatf("stWdata%0d", k), mem_wdata, 32'hDEADBEEF);
            @(negedge clk);
        end
        #4;
        checkOutput("stReqDrop", 32'({mem_req, d_rsp_valid}), 32'h0);
        @(negedge clk); #4;
        checkOutput("stRsp", 32'(d_rsp_valid), 32'h1);
        checkOutput("stRdata", d_rdata, 32'h0);
        @(negedge clk); #4;
        checkOutput("stPulse", 32'(d_rsp_valid), 32'h0);
        gntDelay = 0;

        // Both valids held: streak limiter lets fetch through every fifth grant
        expSeq = 10'b1111011110;
        @(negedge clk);
        if_req_valid = 1'b1; if_addr = 32'h40;
        d_req_valid = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h80; d_wdata = 32'h0;
        nGr = 0;
        for (int c = 0; c < 60 && nGr < 10; c++) begin
            #4;
            if (if_req_ready || d_req_ready) begin
                checkOutput($sformatf("grant%0d", nGr), 32'({if_req_ready, d_req_ready}),
                            expSeq[9 - nGr] ? 32'h1 : 32'h2);
                nGr++;
            end
            @(negedge clk);
        end
        if_req_valid = 1'b0;
        d_req_valid = 1'b0;
        checkOutput("grantCount", 32'(nGr), 32'd10);
        repeat (5) @(negedge clk);

        // Reset while waiting on a load, then a stray completion
        #4;
        memAuto = 1'b0;
        @(negedge clk);
        d_req_valid = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h300;
        #4;
        checkOutput("rwReady", 32'(d_req_ready), 32'h1);
        manGnt = 1'b1;
        @(negedge clk);
        d_req_valid = 1'b0;
        #4;
        checkOutput("rwReq", 32'(mem_req), 32'h1);
        manGnt = 1'b0;
        @(negedge clk); #4;
        checkOutput("rwWaitD", 32'(u_dut.r_state), 32'(ST_WAIT_D));
        @(negedge clk);
        reset_n = 1'b0;
        #4;
        checkOutput("rwOutsA", 32'({if_req_ready, d_req_ready, mem_req, mem_we, mem_be,
                                    if_rsp_valid, d_rsp_valid}), 32'h0);
        checkOutput("rwOutsB", mem_addr | mem_wdata | if_rdata | d_rdata, 32'h0);
        checkOutput("rwState", 32'(u_dut.r_state), 32'(ST_IDLE));
        @(negedge clk);
        reset_n = 1'b1;
        #4;
        manRvalid = 1'b1;
        manRdata = 32'hBAD0BAD0;
        @(negedge clk); #4;
        manRvalid = 1'b0;
        checkOutput("rwStrayState", 32'(u_dut.r_state), 32'(ST_IDLE));
        @(negedge clk); #4;
        checkOutput("rwNoRsp", 32'({if_rsp_valid, d_rsp_valid}), 32'h0);
        checkOutput("rwDRdata", d_rdata, 32'h0);
        memAuto = 1'b1;
        doFetch(32'h0, rd, ok);
        checkOutput("rwFetchDone", 32'(ok), 32'h1);
        checkOutput("rwFetchData", rd, 32'h12345678);

        // Back-to-back fetches: second accept coincides with first response
        @(negedge clk);
        if_req_valid = 1'b1; if_addr = 32'h0;
        #4;
        checkOutput("b2bAcc0", 32'(if_req_ready), 32'h1);
        @(negedge clk);
        if_addr = 32'h4;
        #4;
        checkOutput("b2bBusy1", 32'({if_req_ready, if_rsp_valid}), 32'h0);
        @(negedge clk); #4;
        checkOutput("b2bBusy2", 32'({if_req_ready, if_rsp_valid}), 32'h0);
        @(negedge clk); #4;
        checkOutput("b2bRsp0Acc1", 32'({if_req_ready, if_rsp_valid}), 32'h3);
        checkOutput("b2bData0", if_rdata, 32'h12345678);
        @(negedge clk);
        if_req_valid = 1'b0;
        #4;
        checkOutput("b2bGap4", 32'(if_rsp_valid), 32'h0);
        @(negedge clk); #4;
        checkOutput("b2bGap5", 32'(if_rsp_valid), 32'h0);
        @(negedge clk); #4;
        checkOutput("b2bRsp1", 32'(if_rsp_valid), 32'h1);
        checkOutput("b2bData1", if_rdata, 32'h00500893);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
